turn_controller: RTL and testbench

//  Game-flow FSM for Chicken Cha Cha Cha; it sequences the per-turn datapath.
//  - Accepts a player's card pick and issues the compare strobe to the datapath.
//  - On a match, issues the move strobe and checks for a win.
//  - On a mismatch, holds the reveal window, then pulses next_turn.
//  - Sits between the button/switch front end and data_path; owns turn order and face-up mask.

---
 rtl/turn_controller_pkg.sv | 26 ++
 rtl/turn_controller_if.sv | 37 +++
 rtl/turn_controller_reveal_timer.sv | 40 ++++
 rtl/turn_controller.sv | 147 ++++++++++++++
 tb/tb_turn_controller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/turn_controller_pkg.sv
// Shared definitions for the Chicken Cha Cha Cha turn controller and its datapath.
package turn_controller_pkg;

    localparam int unsigned NUM_CARDS_DEF     = 12;
    localparam int unsigned CARD_W_DEF        = 4;
    localparam int unsigned REVEAL_CYCLES_DEF = 50;
    localparam int unsigned PLAYER_W          = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_SEL,
        ST_COMPARE,
        ST_RESULT,
        ST_MOVE,
        ST_CHK_WIN,
        ST_REVEAL,
        ST_NEXT,
        ST_OVER
    } state_e;

    // A game always has at least two players (highest index >= 1).
    function automatic logic [PLAYER_W-1:0] players_clamp(input logic [PLAYER_W-1:0] n);
        return (n == '0) ? PLAYER_W'(1) : n;
    endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Signals between the turn controller, the button/switch front end and data_path.
interface turn_controller_if
    import turn_controller_pkg::*;
#(
    parameter int unsigned NUM_CARDS = NUM_CARDS_DEF,
    parameter int unsigned CARD_W    = CARD_W_DEF
) ();

    logic                 start;
    logic [PLAYER_W-1:0]  num_players;
    logic                 sel_valid;
    logic [CARD_W-1:0]    sel_card;
    logic                 match;
    logic                 win;

    logic                 compare_strobe;
    logic [CARD_W-1:0]    card_sel;
    logic                 move_strobe;
    logic                 next_turn;
    logic [PLAYER_W-1:0]  turn;
    logic [NUM_CARDS-1:0] face_up;
    logic                 game_over;
    logic [PLAYER_W-1:0]  winner;

    modport master (
        input  start, num_players, sel_valid, sel_card, match, win,
        output compare_strobe, card_sel, move_strobe, next_turn,
               turn, face_up, game_over, winner
    );

    modport slave (
        output start, num_players, sel_valid, sel_card, match, win,
        input  compare_strobe, card_sel, move_strobe, next_turn,
               turn, face_up, game_over, winner
    );

endinterface

// File: rtl/turn_controller_reveal_timer.sv
// Reveal-window timer: load clears it, count advances it, done marks the last cycle.
module turn_controller_reveal_timer #(
    parameter int unsigned REVEAL_CYCLES = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    localparam int unsigned CNT_W = $clog2(REVEAL_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REVEAL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        done_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/turn_controller.sv
// Game-flow FSM: accepts picks, sequences compare/move/next-turn strobes,
// and owns turn order and the face-up mask.
module turn_controller
    import turn_controller_pkg::*;
#(
    parameter int unsigned NUM_CARDS     = NUM_CARDS_DEF,
    parameter int unsigned CARD_W        = CARD_W_DEF,
    parameter int unsigned REVEAL_CYCLES = REVEAL_CYCLES_DEF
) (
    input logic              clk,
    input logic              rst,
    turn_controller_if.master bus
);

    state_e               state_q, state_d;
    logic [PLAYER_W-1:0]  turn_q, turn_d;
    logic [PLAYER_W-1:0]  players_q, players_d;
    logic [NUM_CARDS-1:0] face_up_q, face_up_d;
    logic [CARD_W-1:0]    card_sel_q, card_sel_d;
    logic                 game_over_q, game_over_d;
    logic [PLAYER_W-1:0]  winner_q, winner_d;
    logic                 cmp_q, move_q, next_q;

    logic                 tmr_load, tmr_count, tmr_done;
    logic [NUM_CARDS-1:0] sel_bit;
    logic                 sel_ok;

    // A pick counts only if it names an existing, still face-down card.
    assign sel_bit = NUM_CARDS'(1) << bus.sel_card;
    assign sel_ok  = bus.sel_valid && (32'(bus.sel_card) < NUM_CARDS)
                     && ((face_up_q & sel_bit) == '0);

    turn_controller_reveal_timer #(
        .REVEAL_CYCLES(REVEAL_CYCLES)
    ) u_reveal_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .count_i(tmr_count),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        players_d   = players_q;
        face_up_d   = face_up_q;
        card_sel_d  = card_sel_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        tmr_load    = 1'b0;
        tmr_count   = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                // start beats a simultaneous pick; the pick is simply dropped
                if (bus.start) begin
                    players_d   = players_clamp(bus.num_players);
                    turn_d      = '0;
                    face_up_d   = '0;
                    game_over_d = 1'b0;
                    state_d     = ST_WAIT_SEL;
                end
            end
            ST_WAIT_SEL: begin
                if (sel_ok) begin
                    card_sel_d = bus.sel_card;
                    face_up_d  = face_up_q | sel_bit;
                    state_d    = ST_COMPARE;
                end
            end
            ST_COMPARE: state_d = ST_RESULT;
            ST_RESULT: begin
                if (bus.match) begin
                    state_d = ST_MOVE;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = ST_REVEAL;
                end
            end
            ST_MOVE: state_d = ST_CHK_WIN;
            ST_CHK_WIN: begin
                if (bus.win) begin
                    winner_d    = turn_q;
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else begin
                    // Every card matched without a win: reshuffle by clearing the mask.
                    if (&face_up_q) begin
                        face_up_d = '0;
                    end
                    state_d = ST_WAIT_SEL;
                end
            end
            ST_REVEAL: begin
                if (tmr_done) begin
                    state_d = ST_NEXT;
                end else begin
                    tmr_count = 1'b1;
                end
            end
            ST_NEXT: begin
                face_up_d = '0;
                turn_d    = (turn_q == players_q) ? '0 : turn_q + PLAYER_W'(1);
                state_d   = ST_WAIT_SEL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            turn_q      <= '0;
            players_q   <= '0;
            face_up_q   <= '0;
            card_sel_q  <= '0;
            game_over_q <= 1'b0;
            winner_q    <= '0;
            cmp_q       <= 1'b0;
            move_q      <= 1'b0;
            next_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_q      <= turn_d;
            players_q   <= players_d;
            face_up_q   <= face_up_d;
            card_sel_q  <= card_sel_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            cmp_q       <= (state_d == ST_COMPARE);
            move_q      <= (state_d == ST_MOVE);
            next_q      <= (state_d == ST_NEXT);
        end
    end

    assign bus.compare_strobe = cmp_q;
    assign bus.move_strobe    = move_q;
    assign bus.next_turn      = next_q;
    assign bus.card_sel       = card_sel_q;
    assign bus.turn           = turn_q;
    assign bus.face_up        = face_up_q;
    assign bus.game_over      = game_over_q;
    assign bus.winner         = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Scoreboard bench for turn_controller: picks queue expected strobes, a monitor checks them.
module tb_turn_controller;
    import turn_controller_pkg::*;

    localparam int unsigned R  = 5;
    localparam int unsigned NC = 12;
    localparam int unsigned CW = 4;

    typedef struct {
        int             kind;   // 0 compare, 1 move, 2 next_turn
        int             cyc;
        logic [CW-1:0]  card;
        logic [1:0]     turn;
        logic [NC-1:0]  face;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  sb[$];
    ev_t  e;
    int   act_kind;

    logic [1:0]    m_turn = '0;
    logic [1:0]    m_players = '0;
    logic [NC-1:0] m_face = '0;
    bit            m_over = 1'b0;
    logic [1:0]    m_winner = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    turn_controller_if #(.NUM_CARDS(NC), .CARD_W(CW)) bus ();

    turn_controller #(
        .NUM_CARDS(NC), .CARD_W(CW), .REVEAL_CYCLES(R)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.compare_strobe || bus.move_strobe || bus.next_turn)) begin
            act_kind = bus.compare_strobe ? 0 : (bus.move_strobe ? 1 : 2);
            chk("strobe_onehot", 32'(bus.compare_strobe) + 32'(bus.move_strobe)
                + 32'(bus.next_turn), 32'd1);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, required none",
                         act_kind, cyc);
            end else begin
                e = sb.pop_front();
                chk("ev_kind", 32'(act_kind), 32'(e.kind));
                chk("ev_cycle", 32'(cyc), 32'(e.cyc));
                chk("ev_card_sel", 32'(bus.card_sel), 32'(e.card));
                chk("ev_turn", 32'(bus.turn), 32'(e.turn));
                chk("ev_face_up", 32'(bus.face_up), 32'(e.face));
            end
        end
    end

    task automatic check_model();
        chk("turn", 32'(bus.turn), 32'(m_turn));
        chk("face_up", 32'(bus.face_up), 32'(m_face));
        chk("game_over", 32'(bus.game_over), 32'(m_over));
        if (m_over) chk("winner", 32'(bus.winner), 32'(m_winner));
    endtask

    task automatic start_game(input logic [1:0] np, input bit with_sel);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.num_players = np;
        if (with_sel) begin
            bus.sel_valid = 1'b1;
            bus.sel_card  = CW'(8);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.sel_valid = 1'b0;
        m_players = (np == 2'd0) ? 2'd1 : np;
        m_turn = '0;
        m_face = '0;
        m_over = 1'b0;
        check_model();
        chk("state_after_start", 32'(dut.state_q), 32'(ST_WAIT_SEL));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_turn = '0;
        m_face = '0;
        m_over = 1'b0;
    endtask

    task automatic pick(input int card, input bit m, input bit w);
        bit            acc;
        int            p;
        logic [NC-1:0] bitm;
        bitm = (card < int'(NC)) ? (NC'(1) << card) : '0;
        acc  = !m_over && (card < int'(NC)) && ((m_face & bitm) == '0);
        bus.match = m;
        bus.win   = w;
        @(posedge clk); #1;
        bus.sel_valid = 1'b1;
        bus.sel_card  = CW'(card);
        p = cyc;
        if (acc) begin
            m_face = m_face | bitm;
            sb.push_back('{kind: 0, cyc: p + 1, card: CW'(card), turn: m_turn, face: m_face});
            if (m) sb.push_back('{kind: 1, cyc: p + 3, card: CW'(card), turn: m_turn, face: m_face});
            else   sb.push_back('{kind: 2, cyc: p + 3 + int'(R), card: CW'(card), turn: m_turn, face: m_face});
        end
        @(posedge clk); #1;
        bus.sel_valid = 1'b0;
        if (acc && !m) repeat (R + 3) @(posedge clk);
        else           repeat (4) @(posedge clk);
        #1;
        if (acc) begin
            if (m) begin
                if (w) begin
                    m_over   = 1'b1;
                    m_winner = m_turn;
                end else if (&m_face) begin
                    m_face = '0;
                end
            end else begin
                m_face = '0;
                m_turn = (m_turn == m_players) ? 2'd0 : m_turn + 2'd1;
            end
        end
        check_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int p;
        bus.start = 1'b0;
        bus.num_players = '0;
        bus.sel_valid = 1'b0;
        bus.sel_card = '0;
        bus.match = 1'b0;
        bus.win = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_strobes", {29'd0, bus.compare_strobe, bus.move_strobe, bus.next_turn}, 32'd0);
        chk("rst_face_up", 32'(bus.face_up), 32'd0);
        chk("rst_turn", 32'(bus.turn), 32'd0);
        chk("rst_game_over", 32'(bus.game_over), 32'd0);
        chk("rst_winner", 32'(bus.winner), 32'd0);
        chk("rst_card_sel", 32'(bus.card_sel), 32'd0);

        // Mismatch: three players, card 3 shown then turn passes
        start_game(2'd2, 1'b0);
        pick(3, 1'b0, 1'b0);
        chk("t2_turn", 32'(bus.turn), 32'd1);

        // Reset in the middle of the reveal window
        bus.match = 1'b0;
        @(posedge clk); #1;
        bus.sel_valid = 1'b1;
        bus.sel_card  = CW'(7);
        p = cyc;
        sb.push_back('{kind: 0, cyc: p + 1, card: CW'(7), turn: 2'd1, face: 12'h080});
        @(posedge clk); #1;
        bus.sel_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_in_reveal", 32'(dut.state_q), 32'(ST_REVEAL));
        do_reset();
        chk("t1_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t1_face_up", 32'(bus.face_up), 32'd0);
        chk("t1_turn", 32'(bus.turn), 32'd0);
        chk("t1_strobes", {29'd0, bus.compare_strobe, bus.move_strobe, bus.next_turn}, 32'd0);
        chk("t1_sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();

        // Match chain: same player keeps picking
        start_game(2'd2, 1'b0);
        pick(2, 1'b1, 1'b0);
        pick(5, 1'b1, 1'b0);
        chk("t3_face_up", 32'(bus.face_up), 32'h024);
        chk("t3_turn", 32'(bus.turn), 32'd0);

        // Illegal picks: repeated card and out-of-range card
        pick(2, 1'b1, 1'b0);
        pick(13, 1'b1, 1'b0);
        chk("t5_state", 32'(dut.state_q), 32'(ST_WAIT_SEL));

        // start mid-game is ignored; player count must stay three
        pick(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.num_players = 2'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("ign_start_turn", 32'(bus.turn), 32'd1);
        chk("ign_start_state", 32'(dut.state_q), 32'(ST_WAIT_SEL));
        pick(1, 1'b0, 1'b0);
        chk("ign_start_turn2", 32'(bus.turn), 32'd2);

        // Win by player 2, then picks are dead
        pick(4, 1'b1, 1'b1);
        chk("t4_game_over", 32'(bus.game_over), 32'd1);
        chk("t4_winner", 32'(bus.winner), 32'd2);
        pick(6, 1'b1, 1'b0);
        chk("t4_state", 32'(dut.state_q), 32'(ST_OVER));

        // Restart from OVER with a concurrent pick; num_players=0 means two players
        start_game(2'd0, 1'b1);
        pick(0, 1'b0, 1'b0);
        chk("np0_turn1", 32'(bus.turn), 32'd1);
        pick(1, 1'b0, 1'b0);
        chk("np0_turn0", 32'(bus.turn), 32'd0);

        // Four players wrap, then full-mask clear after twelve matches
        do_reset();
        start_game(2'd3, 1'b0);
        for (int i = 0; i < 4; i++) pick(i, 1'b0, 1'b0);
        chk("t6_wrap_turn", 32'(bus.turn), 32'd0);
        for (int i = 0; i < 11; i++) pick(i, 1'b1, 1'b0);
        chk("t6_face_11", 32'(bus.face_up), 32'h7FF);
        pick(11, 1'b1, 1'b0);
        chk("t6_face_clear", 32'(bus.face_up), 32'h000);
        chk("t6_turn", 32'(bus.turn), 32'd0);
        pick(11, 1'b0, 1'b0);
        chk("t6_after_clear_turn", 32'(bus.turn), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
